dram_responder: RTL and testbench

DRAM_RESPONDER -- requirements
Module: dram_responder

---
 rtl/dram_responder.sv | 153 +++++++++++++++
 tb/tb_dram_responder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_responder.sv
// dram_responder: single-port word memory with latency-pipelined, credit-limited reads.
// Optional stall injection on ra_ack/w_ack is compiled in with DRAM_RESP_STALL_EN.
module dram_responder #(
    parameter int AW  = 10,
    parameter int DW  = 64,
    parameter int LAT = 4,
    parameter int QD  = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          ra_rdy,
    output logic          ra_ack,
    input  logic [AW-1:0] ra_addr,
    output logic          rd_rdy,
    input  logic          rd_ack,
    output logic [DW-1:0] rd_data,
    input  logic          w_rdy,
    output logic          w_ack,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data
);

    localparam int CW = $clog2(QD + 1);
    localparam int PW = (QD > 1) ? $clog2(QD) : 1;
    localparam logic [CW-1:0] QD_C     = CW'(QD);
    localparam logic [PW-1:0] LAST_PTR = PW'(QD - 1);

    logic [DW-1:0] mem [2**AW];

    logic [CW-1:0] outstanding;
    logic [LAT-1:0] pipe_v;
    logic [DW-1:0] pipe_d [LAT];

    logic [DW-1:0] fifo_d [QD];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;

    logic          ra_gate;
    logic          w_gate;
    logic          ra_xfer;
    logic          rd_xfer;
    logic          w_xfer;
    logic          push;
    logic [DW-1:0] rd_word;

`ifdef DRAM_RESP_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Free-running stall pattern, restarted from a fixed seed on reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign ra_gate = lfsr[0];
    assign w_gate  = lfsr[1];
`else
    assign ra_gate = 1'b1;
    assign w_gate  = 1'b1;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Credit check uses only registered state, never rd_ack.
    assign ra_ack  = ra_rdy & ~i_rst & ra_gate & (outstanding < QD_C);
    assign w_ack   = w_rdy & ~i_rst & w_gate;
    assign rd_rdy  = ~i_rst & (fifo_cnt != '0);
    assign rd_data = rd_rdy ? fifo_d[rd_ptr] : '0;

    assign ra_xfer = ra_rdy & ra_ack;
    assign rd_xfer = rd_rdy & rd_ack;
    assign w_xfer  = w_rdy & w_ack;
    assign push    = pipe_v[LAT-1];

    // Same-edge write to the read address is forwarded (write-first).
    assign rd_word = (w_xfer && (w_addr == ra_addr)) ? w_data : mem[ra_addr];

    // Memory array; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_xfer) begin
            mem[w_addr] <= w_data;
        end
    end

    // Reads accepted but not yet returned (pipeline plus FIFO).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            outstanding <= '0;
        end else if (ra_xfer && !rd_xfer) begin
            outstanding <= outstanding + 1'b1;
        end else if (!ra_xfer && rd_xfer) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    // Latency pipeline valid bits; cleared to drop in-flight reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= ra_xfer;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
            end
        end
    end

    // Latency pipeline data; qualified by pipe_v so no reset needed.
    always_ff @(posedge i_clk) begin
        pipe_d[0] <= rd_word;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] <= pipe_d[i-1];
        end
    end

    // Response FIFO storage.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_d[wr_ptr] <= pipe_d[LAT-1];
        end
    end

    // Response FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_xfer) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !rd_xfer) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (!push && rd_xfer) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: directed vectors plus random traffic for dram_responder.
// Reference model: word array plus an ordered queue of {data, ready cycle}.
module tb_dram_responder;

    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int LAT = 4;
    localparam int QD  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ra_rdy;
    logic          ra_ack;
    logic [AW-1:0] ra_addr;
    logic          rd_rdy;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          w_rdy;
    logic          w_ack;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    always #5 clk = ~clk;

    dram_responder #(.AW(AW), .DW(DW), .LAT(LAT), .QD(QD)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .ra_rdy (ra_rdy),
        .ra_ack (ra_ack),
        .ra_addr(ra_addr),
        .rd_rdy (rd_rdy),
        .rd_ack (rd_ack),
        .rd_data(rd_data),
        .w_rdy  (w_rdy),
        .w_ack  (w_ack),
        .w_addr (w_addr),
        .w_data (w_data)
    );

    typedef struct {
        logic [63:0] data;
        int          rdy;
    } rd_ent_t;

    typedef struct {
        bit          same;
        logic [9:0]  wa;
        logic [63:0] wd;
        logic [9:0]  ra;
        logic [63:0] ed;
    } vec_t;

    rd_ent_t     q[$];
    logic [63:0] mmem [int];

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          ra_stalls = 0;
    int          w_stalls = 0;
    int          last_cyc;
    logic        last_rd_rdy;
    logic [63:0] last_rd_data;
    logic        last_ra_x;
    logic        last_w_x;

    function automatic logic [63:0] pat(input int a);
        return {16'hC0DE, a[15:0], 32'hFFFF_0000 ^ a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s @cyc %0d: got %h, expected %h",
                     nm, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: check outputs against the model, then advance it.
    task automatic step();
        logic        exp_rdy;
        logic [63:0] exp_d;
        logic        exp_ra;
        logic        rx;
        logic        wx;
        logic        dx;
        #1;
        exp_rdy = 1'b0;
        exp_d   = 64'd0;
        if (!rst && q.size() > 0) begin
            if (q[0].rdy <= cyc) begin
                exp_rdy = 1'b1;
                exp_d   = q[0].data;
            end
        end
        exp_ra = !rst && ra_rdy && (q.size() < QD);
        chk("rd_rdy", rd_rdy, exp_rdy);
        chk("rd_data", rd_data, exp_d);
`ifdef DRAM_RESP_STALL_EN
        if (exp_ra && !ra_ack) ra_stalls++;
        if (!rst && w_rdy && !w_ack) w_stalls++;
        chk("ra_ack_no_credit", ra_ack && !exp_ra, 64'd0);
        chk("w_ack_illegal", w_ack && !(w_rdy && !rst), 64'd0);
`else
        chk("ra_ack", ra_ack, exp_ra);
        chk("w_ack", w_ack, w_rdy && !rst);
`endif
        rx = !rst && ra_rdy && ra_ack;
        wx = !rst && w_rdy && w_ack;
        dx = exp_rdy && rd_ack;
        last_cyc     = cyc;
        last_rd_rdy  = rd_rdy;
        last_rd_data = rd_data;
        last_ra_x    = rx;
        last_w_x     = wx;
        if (rst) begin
            q.delete();
        end else begin
            if (dx) void'(q.pop_front());
            if (wx) mmem[int'(w_addr)] = w_data;
            if (rx) q.push_back('{mmem[int'(ra_addr)], cyc + 1 + LAT});
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        ra_rdy = 1'b0;
        w_rdy  = 1'b0;
        rd_ack = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (q.size() == 0) break;
            step();
        end
    endtask

    task automatic do_write(input logic [9:0] a, input logic [63:0] d);
        bit ok = 1'b0;
        w_addr = a;
        w_data = d;
        w_rdy  = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (last_w_x) begin
                ok = 1'b1;
                break;
            end
        end
        w_rdy = 1'b0;
        chk("w_timeout", ok, 64'd1);
    endtask

    task automatic wait_rd(input int c0, output logic [63:0] d,
                           output int lat);
        bit ok = 1'b0;
        d   = '0;
        lat = -1;
        rd_ack = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (last_rd_rdy) begin
                ok  = 1'b1;
                d   = last_rd_data;
                lat = last_cyc - (c0 + 1);
                break;
            end
        end
        chk("rd_timeout", ok, 64'd1);
    endtask

    task automatic read_one(input logic [9:0] a, output logic [63:0] d,
                            output int lat);
        bit ok = 1'b0;
        int c0 = 0;
        rd_ack  = 1'b1;
        ra_addr = a;
        ra_rdy  = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (last_ra_x) begin
                ok = 1'b1;
                c0 = last_cyc;
                break;
            end
        end
        ra_rdy = 1'b0;
        chk("ra_timeout", ok, 64'd1);
        wait_rd(c0, d, lat);
    endtask

    // Write and read of one address; the read never precedes the write.
    task automatic wr_rd_same(input logic [9:0] a, input logic [63:0] wd,
                              output logic [63:0] d, output int lat);
        bit wdone = 1'b0;
        bit rdone = 1'b0;
        int c0 = 0;
        rd_ack  = 1'b1;
        w_addr  = a;
        w_data  = wd;
        ra_addr = a;
        for (int n = 0; n < 50; n++) begin
            w_rdy  = !wdone;
            ra_rdy = !rdone;
            #1;
            if (!wdone && !w_ack) ra_rdy = 1'b0;
            step();
            if (last_w_x) wdone = 1'b1;
            if (last_ra_x) begin
                rdone = 1'b1;
                c0 = last_cyc;
            end
            if (wdone && rdone) break;
        end
        w_rdy  = 1'b0;
        ra_rdy = 1'b0;
        chk("same_timeout", wdone && rdone, 64'd1);
        wait_rd(c0, d, lat);
    endtask

    vec_t tv[6];

    initial begin
        logic [63:0] d;
        int          lat;
        int          idx;
        int          npop;
        int          a;
        int          c;
        logic [63:0] got[$];
        int          acc_a[$];
        int          acc_c[$];

        tv[0] = '{1'b0, 10'd5,    64'h1122_3344_5566_7788, 10'd5,
                  64'h1122_3344_5566_7788};
        tv[1] = '{1'b1, 10'd9,    64'h0000_0000_0000_DEAD, 10'd9,
                  64'h0000_0000_0000_DEAD};
        tv[2] = '{1'b0, 10'd1023, 64'hFFFF_FFFF_FFFF_FFFF, 10'd1023,
                  64'hFFFF_FFFF_FFFF_FFFF};
        tv[3] = '{1'b0, 10'd0,    64'h0,                   10'd0,
                  64'h0};
        tv[4] = '{1'b0, 10'd10,   64'hA5A5_A5A5_5A5A_5A5A, 10'd5,
                  64'h1122_3344_5566_7788};
        tv[5] = '{1'b1, 10'd5,    64'h0123_4567_89AB_CDEF, 10'd5,
                  64'h0123_4567_89AB_CDEF};

        rst     = 1'b1;
        ra_rdy  = 1'b1;
        ra_addr = '0;
        rd_ack  = 1'b0;
        w_rdy   = 1'b1;
        w_addr  = '0;
        w_data  = '0;
        @(negedge clk);
        step();
        step();
        rst    = 1'b0;
        ra_rdy = 1'b0;
        w_rdy  = 1'b0;

        for (int i = 0; i < 32; i++) do_write(10'(i), pat(i));

        // Credit limit with rd_ack held low, then in-order return.
        drain();
        rd_ack = 1'b0;
        ra_rdy = 1'b1;
        idx = 0;
        for (int n = 0; n < 40; n++) begin
            ra_addr = 10'(idx);
            step();
            if (last_ra_x) idx++;
        end
        chk("credit_accepts", idx, QD);
        #1;
        chk("credit_block", ra_ack, 64'd0);
        rd_ack = 1'b1;
        for (int n = 0; n < 120 && got.size() < 8; n++) begin
            ra_rdy  = (idx < 8);
            ra_addr = 10'(idx);
            step();
            if (last_ra_x) idx++;
            if (last_rd_rdy) got.push_back(last_rd_data);
        end
        ra_rdy = 1'b0;
        chk("order_count", got.size(), 8);
        for (int k = 0; k < got.size(); k++) begin
            chk($sformatf("order_%0d", k), got[k], pat(k));
        end

        // Back-to-back reads with rd_ack held high.
        drain();
        rd_ack = 1'b1;
        idx  = 8;
        npop = 0;
        for (int n = 0; n < 200 && npop < 16; n++) begin
            ra_rdy  = (idx < 24);
            ra_addr = 10'(idx);
            step();
            if (last_ra_x) begin
                acc_a.push_back(idx);
                acc_c.push_back(last_cyc);
                idx++;
            end
            if (last_rd_rdy && acc_a.size() > 0) begin
                a = acc_a.pop_front();
                c = acc_c.pop_front();
                chk("b2b_data", last_rd_data, pat(a));
                chk("b2b_lat", last_cyc - c - 1, LAT);
                npop++;
            end
        end
        ra_rdy = 1'b0;
        chk("b2b_count", npop, 16);

        // Table of write/read vectors with expected data and latency.
        for (int i = 0; i < 6; i++) begin
            drain();
            if (tv[i].same) begin
                wr_rd_same(tv[i].wa, tv[i].wd, d, lat);
            end else begin
                do_write(tv[i].wa, tv[i].wd);
                read_one(tv[i].ra, d, lat);
            end
            chk($sformatf("vec%0d_data", i), d, tv[i].ed);
            chk($sformatf("vec%0d_lat", i), lat, LAT);
        end

        // Reset with three reads in flight.
        drain();
        rd_ack = 1'b0;
        ra_rdy = 1'b1;
        idx = 0;
        for (int n = 0; n < 50 && idx < 3; n++) begin
            ra_addr = 10'(idx + 1);
            step();
            if (last_ra_x) idx++;
            if (idx == 3) ra_rdy = 1'b0;
        end
        ra_rdy = 1'b0;
        chk("pre_rst_reads", idx, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_ack = 1'b1;
        #1;
        chk("rst_rd_rdy", rd_rdy, 64'd0);
        chk("rst_outstanding", dut.outstanding, 64'd0);
        for (int n = 0; n < LAT + 4; n++) step();
        read_one(10'd5, d, lat);
        chk("mem_keep_5", d, 64'h0123_4567_89AB_CDEF);
        read_one(10'd1023, d, lat);
        chk("mem_keep_1023", d, 64'hFFFF_FFFF_FFFF_FFFF);
        read_one(10'd2, d, lat);
        chk("mem_keep_2", d, pat(2));

        // Random concurrent traffic against the model.
        drain();
        for (int n = 0; n < 1000; n++) begin
            ra_rdy  = 1'($urandom_range(1, 0));
            ra_addr = 10'($urandom_range(31, 0));
            w_rdy   = 1'($urandom_range(1, 0));
            w_addr  = 10'($urandom_range(31, 0));
            w_data  = {$urandom(), $urandom()};
            rd_ack  = ($urandom_range(3, 0) != 0);
            step();
        end
        drain();
`ifdef DRAM_RESP_STALL_EN
        chk("ra_stall_seen", ra_stalls > 0, 64'd1);
        chk("w_stall_seen", w_stalls > 0, 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
